// File: rtl/fb_pkg.sv
// Shared definitions for the ping-pong frame buffer.
//
// Contents:
//   bank_state_t   - per-bank occupancy encoding (FB_FREE=0, FB_FULL=1)
//   FB_DATA_W      - default pixel word width
//   FB_ADDR_W      - default per-bank address width (DEPTH = 2**FB_ADDR_W)
//   FB_RD_LATENCY  - cycles from an accepted read to rd_valid; follows the
//                    FRAME_BUFFER_OUT_REG_EN build macro so benches can align
//                    their expectations with whichever build they are checking.
package fb_pkg;

    typedef enum logic {
        FB_FREE = 1'b0,
        FB_FULL = 1'b1
    } bank_state_t;

    localparam int FB_DATA_W = 16;
    localparam int FB_ADDR_W = 10;

`ifdef FRAME_BUFFER_OUT_REG_EN
    localparam int FB_RD_LATENCY = 2;
`else
    localparam int FB_RD_LATENCY = 1;
`endif

endpackage

// File: rtl/sdp_ram_1clk.sv
// Simple dual-port, single-clock RAM with a registered read port.
// Written without any reset so synthesis maps it onto block RAM; the read
// register only updates on re, so the last read word holds otherwise.
//
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable
//   raddr  - read address
//   rdata  - registered read data (valid the cycle after re)
module sdp_ram_1clk #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write and read share one clock; a same-address collision is never
    // exercised by the frame buffer because writer and reader own different
    // banks.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered (ping-pong) frame store. A streaming writer fills one bank
// while a random-access reader consumes the other; banks are handed over via
// a per-bank FREE/FULL flag. Both banks live in one RAM of 2*DEPTH words with
// the bank-select bit as address MSB.
//
// Build option:
//   FRAME_BUFFER_OUT_REG_EN - adds one output register on rd_data/rd_valid
//                             (read latency 2 instead of 1).
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   wr_en/wr_data   - pixel write strobe and data (accepted when wr_ready)
//   wr_last         - last pixel of the frame, qualified by wr_en
//   wr_ready        - current write bank is FREE and not in reset
//   err_drop        - sticky flag: a write was attempted while not ready
//   rd_frame_valid  - current read bank holds a complete frame
//   rd_frame_len    - pixel count of that frame
//   rd_en/rd_addr   - random-access read strobe and word address
//   rd_data/rd_valid- read data and its one-cycle valid pulse
//   rd_done         - reader releases the current read bank
module frame_buffer_pingpong
    import fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              err_drop,
    output logic              rd_frame_valid,
    output logic [ADDR_W:0]   rd_frame_len,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_done
);

    bank_state_t       bank [2];
    logic [ADDR_W:0]   len  [2];
    logic              wsel;
    logic              rsel;
    logic [ADDR_W-1:0] wcnt;

    logic              wr_accept;
    logic              close_frame;
    logic              rd_accept;
    logic              release_bank;

    logic [DATA_W-1:0] ram_q;
    logic              ram_q_seen;
    logic              stage1_valid;
    logic [DATA_W-1:0] stage1_data;

    // Handshake decode. A frame closes on wr_last or when the bank is full,
    // so the counter never wraps inside a bank. Close and release can never
    // hit the same bank: close needs that bank FREE, release needs it FULL.
    assign wr_ready       = !rst && (bank[wsel] == FB_FREE);
    assign wr_accept      = wr_en && wr_ready;
    assign close_frame    = wr_accept && (wr_last || (wcnt == '1));
    assign rd_frame_valid = (bank[rsel] == FB_FULL);
    assign rd_frame_len   = len[rsel];
    assign rd_accept      = rd_en && rd_frame_valid;
    assign release_bank   = rd_done && rd_frame_valid;

    // Bank ownership, write counter, stored lengths and the drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank[0]  <= FB_FREE;
            bank[1]  <= FB_FREE;
            len[0]   <= '0;
            len[1]   <= '0;
            wsel     <= 1'b0;
            rsel     <= 1'b0;
            wcnt     <= '0;
            err_drop <= 1'b0;
        end else begin
            if (wr_en && !wr_ready) begin
                err_drop <= 1'b1;
            end
            if (wr_accept) begin
                wcnt <= wcnt + 1'b1;
            end
            if (close_frame) begin
                bank[wsel] <= FB_FULL;
                len[wsel]  <= {1'b0, wcnt} + 1'b1;
                wsel       <= ~wsel;
                wcnt       <= '0;
            end
            if (release_bank) begin
                bank[rsel] <= FB_FREE;
                rsel       <= ~rsel;
            end
        end
    end

    sdp_ram_1clk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr ({wsel, wcnt}),
        .wdata (wr_data),
        .re    (rd_accept),
        .raddr ({rsel, rd_addr}),
        .rdata (ram_q)
    );

    // The RAM read register carries no reset, so rd_data is forced to zero
    // until the first read after reset; afterwards the RAM register's own
    // hold behaviour keeps rd_data stable between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_valid <= 1'b0;
            ram_q_seen   <= 1'b0;
        end else begin
            stage1_valid <= rd_accept;
            if (rd_accept) begin
                ram_q_seen <= 1'b1;
            end
        end
    end

    assign stage1_data = ram_q_seen ? ram_q : '0;

`ifdef FRAME_BUFFER_OUT_REG_EN
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    // Extra output stage for timing closure; adds one cycle of read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= stage1_data;
            out_valid <= stage1_valid;
        end
    end

    assign rd_data  = out_data;
    assign rd_valid = out_valid;
`else
    assign rd_data  = stage1_data;
    assign rd_valid = stage1_valid;
`endif

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Self-checking bench for frame_buffer_pingpong (DATA_W=16, ADDR_W=3).
// Read expectations are queued when a read is issued and compared when
// rd_valid appears; status outputs are compared against fixed values.
module tb_frame_buffer_pingpong;
    import fb_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_done = 1'b0;
    logic          wr_ready;
    logic          err_drop;
    logic          rd_frame_valid;
    logic [AW:0]   rd_frame_len;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] lastRd = '0;

    logic [DW-1:0] mMem [2*DEPTH];
    logic          mFull [2];
    logic          mWsel;
    logic          mRsel;
    int            mWcnt;

    frame_buffer_pingpong #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_last        (wr_last),
        .wr_ready       (wr_ready),
        .err_drop       (err_drop),
        .rd_frame_valid (rd_frame_valid),
        .rd_frame_len   (rd_frame_len),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_done        (rd_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Read results are compared on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (sb.size() == 0) begin
                checkOutput("rdValidSpurious", {31'b0, rd_valid}, 32'd0);
            end else begin
                lastRd = sb.pop_front();
                checkOutput("rdData", {16'b0, rd_data}, {16'b0, lastRd});
            end
        end
    end

    // A close and a release must never target the same bank.
    always @(posedge clk) begin
        if (!rst && dut.close_frame && dut.release_bank) begin
            assert (dut.wsel != dut.rsel)
            else begin
                errors++;
                $display("[TB] FAIL closeReleaseSameBank: wsel %0d rsel %0d", dut.wsel, dut.rsel);
            end
        end
    end

    // One clock of stimulus; the reference model decides acceptance from its
    // own bank flags and queues the expected read word.
    task automatic applyStimulus(input logic we, input logic [DW-1:0] wd, input logic wl,
                                 input logic re, input logic [AW-1:0] ra, input logic rdn);
        logic wacc, racc, rel, cl, ws, rs;
        wr_en = we; wr_data = wd; wr_last = wl;
        rd_en = re; rd_addr = ra; rd_done = rdn;
        ws   = mWsel;
        rs   = mRsel;
        wacc = we && !mFull[ws];
        cl   = wacc && (wl || (mWcnt == DEPTH - 1));
        racc = re && mFull[rs];
        rel  = rdn && mFull[rs];
        if (racc) sb.push_back(mMem[{rs, ra}]);
        @(posedge clk);
        if (wacc) begin
            mMem[{ws, mWcnt[AW-1:0]}] = wd;
            mWcnt = cl ? 0 : mWcnt + 1;
        end
        if (cl) begin
            mFull[ws] = 1'b1;
            mWsel     = !ws;
        end
        if (rel) begin
            mFull[rs] = 1'b0;
            mRsel     = !rs;
        end
        #1;
        wr_en = 1'b0; wr_data = '0; wr_last = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    endtask

    task automatic writeFrame(input logic [DW-1:0] base, input int n, input logic withLast);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, base + DW'(i), withLast && (i == n - 1), 1'b0, '0, 1'b0);
    endtask

    task automatic readFrame(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, 1'b0, 1'b1, AW'(i), 1'b0);
    endtask

    task automatic releaseBank();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic drain();
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("scoreboardEmpty", sb.size(), 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rstWrReady", {31'b0, wr_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("rstRdValid", {31'b0, rd_valid}, 32'd0);
        checkOutput("rstRdData", {16'b0, rd_data}, 32'd0);
        checkOutput("rstFrameValid", {31'b0, rd_frame_valid}, 32'd0);
        checkOutput("rstErrDrop", {31'b0, err_drop}, 32'd0);
        rst      = 1'b0;
        mFull[0] = 1'b0;
        mFull[1] = 1'b0;
        mWsel    = 1'b0;
        mRsel    = 1'b0;
        mWcnt    = 0;
        lastRd   = '0;
        sb.delete();
        #1;
        checkOutput("postRstWrReady", {31'b0, wr_ready}, 32'd1);
    endtask

    initial begin
        $display("[TB] frame_buffer_pingpong bench, read latency %0d", FB_RD_LATENCY);

        // Basic ping-pong: 8-pixel frame, read back, release.
        doReset();
        writeFrame(16'h0001, 8, 1'b1);
        checkOutput("t1FrameValid", {31'b0, rd_frame_valid}, 32'd1);
        checkOutput("t1FrameLen", {28'b0, rd_frame_len}, 32'd8);
        checkOutput("t1WrReady", {31'b0, wr_ready}, 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 3'd0, 1'b0);
        checkOutput("t1Latency", {31'b0, rd_valid}, (FB_RD_LATENCY == 1) ? 32'd1 : 32'd0);
        for (int i = 1; i < 8; i++)
            applyStimulus(1'b0, '0, 1'b0, 1'b1, AW'(i), 1'b0);
        releaseBank();
        drain();
        checkOutput("t1Released", {31'b0, rd_frame_valid}, 32'd0);

        // Back-pressure: both banks full, dropped write must not corrupt bank 0.
        doReset();
        writeFrame(16'h0100, 4, 1'b1);
        writeFrame(16'h0200, 4, 1'b1);
        checkOutput("t2WrReadyLow", {31'b0, wr_ready}, 32'd0);
        applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("t2ErrDrop", {31'b0, err_drop}, 32'd1);
        checkOutput("t2FrameLen", {28'b0, rd_frame_len}, 32'd4);
        readFrame(4);
        releaseBank();
        checkOutput("t2WrReadyBack", {31'b0, wr_ready}, 32'd1);
        checkOutput("t2SecondValid", {31'b0, rd_frame_valid}, 32'd1);
        readFrame(4);
        releaseBank();
        drain();
        checkOutput("t2ErrSticky", {31'b0, err_drop}, 32'd1);

        // Reset mid-frame with bank 0 full; drop flag from above must clear.
        writeFrame(16'h0300, 4, 1'b1);
        writeFrame(16'h0400, 3, 1'b0);
        doReset();
        checkOutput("t5FrameValid", {31'b0, rd_frame_valid}, 32'd0);
        checkOutput("t5WrReady", {31'b0, wr_ready}, 32'd1);
        checkOutput("t5ErrDrop", {31'b0, err_drop}, 32'd0);
        writeFrame(16'h0500, 2, 1'b1);
        checkOutput("t5NewValid", {31'b0, rd_frame_valid}, 32'd1);
        checkOutput("t5NewLen", {28'b0, rd_frame_len}, 32'd2);
        readFrame(2);
        releaseBank();
        drain();

        // Auto-close at DEPTH pixels; next write starts bank 1 at address 0.
        doReset();
        writeFrame(16'h0600, 8, 1'b0);
        checkOutput("t3FrameValid", {31'b0, rd_frame_valid}, 32'd1);
        checkOutput("t3FrameLen", {28'b0, rd_frame_len}, 32'd8);
        checkOutput("t3WrReady", {31'b0, wr_ready}, 32'd1);
        applyStimulus(1'b1, 16'h0AAA, 1'b1, 1'b0, '0, 1'b0);
        readFrame(8);
        releaseBank();
        checkOutput("t3Bank1Valid", {31'b0, rd_frame_valid}, 32'd1);
        checkOutput("t3Bank1Len", {28'b0, rd_frame_len}, 32'd1);
        readFrame(1);
        releaseBank();
        drain();

        // Close of bank 1 coincides with read+release of bank 0.
        doReset();
        writeFrame(16'h0700, 4, 1'b1);
        writeFrame(16'h0800, 2, 1'b0);
        applyStimulus(1'b1, 16'h0802, 1'b1, 1'b1, 3'd2, 1'b1);
        checkOutput("t4FrameValid", {31'b0, rd_frame_valid}, 32'd1);
        checkOutput("t4FrameLen", {28'b0, rd_frame_len}, 32'd3);
        checkOutput("t4WrReady", {31'b0, wr_ready}, 32'd1);
        readFrame(3);
        releaseBank();
        drain();

        // Ignored strobes with no frame present.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 3'd5, 1'b1);
        checkOutput("t6RdValid", {31'b0, rd_valid}, 32'd0);
        checkOutput("t6RdDataHold", {16'b0, rd_data}, {16'b0, lastRd});
        checkOutput("t6FrameValid", {31'b0, rd_frame_valid}, 32'd0);
        checkOutput("t6WrReady", {31'b0, wr_ready}, 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("t6RdValidLate", {31'b0, rd_valid}, 32'd0);
        checkOutput("t6RdDataLate", {16'b0, rd_data}, {16'b0, lastRd});
        writeFrame(16'h0900, 1, 1'b1);
        checkOutput("t6NextValid", {31'b0, rd_frame_valid}, 32'd1);
        checkOutput("t6NextLen", {28'b0, rd_frame_len}, 32'd1);
        readFrame(1);
        releaseBank();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
